uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver: the counterpart to the existing UART transmitter (ready/send/data/tx).
- Samples a serial rx line and delivers each received byte as a parallel word with a one-cycle valid strobe.
- Used for loopback testing of the transmitter on the board, and as the host-command input path for the top level.
- Framing errors and glitched start bits are detected and reported; they never produce a valid strobe.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- CLKS_PER_BIT is a localparam = CLK_FREQ/BAUD (integer divide); must be >= 4.
- HALF_BIT is a localparam = CLKS_PER_BIT/2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- rx  input  1  serial line, idle high, asynchronous to clk.
- data  output  8  last correctly received byte, LSB first on the line.
- valid  output  1  one-cycle pulse: data just updated.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Synchronizer: rx passes through a 2-FF synchronizer; sync flops reset to 1. All decisions use the synchronized value rx_s.
- Reset (rst=0, any time, including mid-frame): state=IDLE, counters=0, shift register=0, data=8'h00, valid=0, frame_err=0, busy=0. A frame in progress is discarded.
- Counters: cnt is wide enough for CLKS_PER_BIT-1; bit_idx is 3 bits.
- IDLE: when rx_s==0, go to START with cnt=0.
- START: cnt increments each cycle. At cnt==HALF_BIT-1, rx_s is sampled:
  - 0: go to DATA, cnt=0, bit_idx=0.
  - 1: glitch; return to IDLE with no outputs.
- DATA: at cnt==CLKS_PER_BIT-1 (mid-bit):
  - shift rx_s into the shift register MSB, shifting right, so the first bit ends up in bit 0;
  - cnt=0, bit_idx++;
  - after the sample with bit_idx==7, go to STOP.
- STOP: at cnt==CLKS_PER_BIT-1, rx_s is sampled:
  - 1: data<=shift register; valid=1 for exactly the next cycle; go to IDLE.
  - 0: frame_err=1 for exactly the next cycle; data is unchanged; go to BREAK.
- BREAK: stay until rx_s==1, then go to IDLE. This prevents a held-low line from retriggering frames.
- valid and frame_err are registered and never high in the same cycle.
- Latency: valid rises CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 3 cycles (±1) after the falling edge of rx. This includes the 2 synchronizer cycles.
- Back-to-back frames: a start bit that follows the stop-bit sample is accepted; IDLE is re-entered half a bit before the stop bit ends, so consecutive frames with no gap are received.
- Mid-frame noise: only the mid-bit sample counts; there is no majority vote.
- No flow control and no overrun flag: the consumer must take data on the valid cycle. data is held until the next valid.

Test Plan:
All scenarios use CLK_FREQ=16, BAUD=1 (CLKS_PER_BIT=16, HALF_BIT=8).
- Reset: hold rst=0 with rx toggling -> data=00, valid=0, frame_err=0, busy=0. Release -> busy stays 0 while rx=1.
- Single byte 8'hA5 (bits 1,0,1,0,0,1,0,1 LSB first, stop=1) -> exactly one valid pulse, data=A5, frame_err never high, busy returns to 0.
- Back-to-back 8'h00 then 8'hFF with no idle gap -> two valid pulses 160 cycles apart, data=00 then FF.
- Glitch: rx low for 4 cycles then high -> returns to IDLE, no valid, no frame_err. A following 8'h3C frame is received correctly.
- Framing error: 8'h55 with stop bit low, rx held low 40 more cycles, then high, then a 8'h81 frame -> one frame_err pulse and data stays 00. The 8'h81 frame then gives valid with data=81.
- Reset mid-frame: assert rst during bit 4 of 8'hF0, release, send 8'h12 -> no valid for the aborted frame; valid with data=12.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples rx at mid-bit and emits each byte with a
// one-cycle valid strobe; bad stop bits give a one-cycle frame_err strobe.
module uart_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  logic cnt_at_last;
  logic cnt_at_half;

  assign cnt_at_last = (cnt_q == CNT_LAST);
  assign cnt_at_half = (cnt_q == CNT_HALF);

  // State and datapath registers; sync flops reset to the idle line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state, counters and shift register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt_at_half) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_at_last) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (cnt_at_last) begin
          cnt_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_BREAK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output strobes are decided here and registered, so each lasts one cycle.
  always_comb begin
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    data_d  = data_q;
    busy    = (state_q != S_IDLE);

    if (state_q == S_STOP && cnt_at_last) begin
      if (rx_s_q) begin
        valid_d = 1'b1;
        data_d  = shift_q;
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; a queue of expected
// strobes (time, kind, byte) is checked against the DUT every cycle.
module tb_uart_rx;

  localparam int CPB     = 16;
  localparam int LATENCY = CPB / 2 + 9 * CPB + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int ferr_cnt    = 0;

  typedef struct {
    int         t;
    bit         err;
    logic [7:0] b;
  } ev_t;

  ev_t        q[$];
  int         vtimes[$];
  logic [7:0] exp_data = 8'h00;

  uart_rx #(
    .CLK_FREQ(16),
    .BAUD    (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] got,
                              input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Model: every frame sent leaves one strobe due LATENCY cycles after its
  // start edge (tolerance +-1); data holds the last good byte in between.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      exp_data = 8'h00;
      chk("rst_data", {24'h0, data}, 32'h0);
      chk("rst_valid", {31'h0, valid}, 32'h0);
      chk("rst_ferr", {31'h0, frame_err}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
    end else if (valid === 1'b1 && frame_err === 1'b1) begin
      chk("valid_and_ferr", 32'h1, 32'h0 + frame_err - 1);
    end else if (valid === 1'b1 || frame_err === 1'b1) begin
      if (frame_err === 1'b1) ferr_cnt++;
      if (valid === 1'b1) vtimes.push_back(cyc);
      if (q.size() == 0) begin
        chk("unexpected_pulse", q.size(), 1);
      end else begin
        ev_t h;
        h = q.pop_front();
        chk("pulse_kind_ferr", {31'h0, frame_err}, {31'h0, h.err});
        chk("pulse_time_ok", (cyc >= h.t - 1 && cyc <= h.t + 1) ? 1 : 0, 1);
        if (valid === 1'b1) begin
          chk("pulse_data", {24'h0, data}, {24'h0, h.b});
          exp_data = h.b;
        end
      end
    end else begin
      chk("held_data", {24'h0, data}, {24'h0, exp_data});
      if (q.size() > 0 && cyc > q[0].t + 1) begin
        chk("missing_pulse", {31'h0, valid | frame_err}, 32'h1);
        void'(q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit);
    ev_t e;
    rx    = 1'b0;
    e.t   = cyc + LATENCY;
    e.err = !stop_bit;
    e.b   = b;
    q.push_back(e);
    tick(CPB);
    for (int unsigned i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
  endtask

  initial begin
    int n;
    logic [7:0] f0;

    // Reset held with a toggling line.
    tick(1);
    for (int unsigned i = 0; i < 20; i++) begin
      rx = ~rx;
      tick(1);
    end
    rx  = 1'b1;
    rst = 1'b1;
    tick(10);
    chk("busy_after_reset", {31'h0, busy}, 32'h0);

    // Single byte A5.
    send(8'hA5, 1'b1);
    tick(20);
    chk("a5_data", {24'h0, data}, 32'hA5);
    chk("a5_pulses", vtimes.size(), 1);
    chk("a5_busy", {31'h0, busy}, 32'h0);

    // Back-to-back 00 then FF, no gap.
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    tick(20);
    n = vtimes.size();
    chk("b2b_pulses", n, 3);
    if (n >= 2) chk("b2b_spacing", vtimes[n-1] - vtimes[n-2], 160);
    chk("b2b_data", {24'h0, data}, 32'hFF);

    // Glitched start bit, then 3C.
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(4);
    chk("glitch_busy", {31'h0, busy}, 32'h1);
    tick(36);
    chk("glitch_busy_idle", {31'h0, busy}, 32'h0);
    chk("glitch_no_valid", vtimes.size(), 3);
    chk("glitch_no_ferr", ferr_cnt, 0);
    send(8'h3C, 1'b1);
    tick(20);
    chk("3c_data", {24'h0, data}, 32'h3C);

    // Framing error from a cleared state, then 81.
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(5);
    send(8'h55, 1'b0);
    tick(40);
    chk("ferr_break_busy", {31'h0, busy}, 32'h1);
    chk("ferr_count", ferr_cnt, 1);
    chk("ferr_data_kept", {24'h0, data}, 32'h00);
    rx = 1'b1;
    tick(20);
    chk("ferr_idle", {31'h0, busy}, 32'h0);
    send(8'h81, 1'b1);
    tick(20);
    chk("81_data", {24'h0, data}, 32'h81);
    chk("81_ferr_count", ferr_cnt, 1);

    // Reset during bit 4 of F0, then 12.
    n  = vtimes.size();
    f0 = 8'hF0;
    rx = 1'b0;
    tick(CPB);
    for (int unsigned i = 0; i < 4; i++) begin
      rx = f0[i];
      tick(CPB);
    end
    rx = f0[4];
    tick(8);
    chk("midframe_busy", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    tick(5);
    rst = 1'b1;
    rx  = 1'b1;
    tick(20);
    chk("abort_no_valid", vtimes.size(), n);
    chk("abort_data", {24'h0, data}, 32'h00);
    send(8'h12, 1'b1);
    tick(20);
    chk("12_data", {24'h0, data}, 32'h12);
    chk("12_pulses", vtimes.size(), n + 1);

    tick(200);
    chk("no_pending", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
